// File: rtl/mem_wb_skid_pkg.sv
// Shared MEM->WB definitions: skid FSM encodings, entry field widths and the
// {wb_en, dest, value} packing used by the write-back path and the hazard unit.
package mem_wb_skid_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_REG_AW = 4;
    localparam int WB_ENTRY_W = 1 + WB_REG_AW + WB_DATA_W;

    // State value equals the number of buffered entries.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic                 wb_en;
        logic [WB_REG_AW-1:0] dest;
        logic [WB_DATA_W-1:0] value;
    } wb_entry_t;

endpackage

// File: rtl/mem_wb_skid_stage_wb_entry_reg.sv
// One buffered write-back slot: a valid flag plus a packed entry, with
// synchronous clear (priority over load) and asynchronous active-low reset.
module wb_entry_reg #(
    parameter int ENTRY_W = 37
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic               valid_d,
    input  logic [ENTRY_W-1:0] entry_d,
    output logic               valid_q,
    output logic [ENTRY_W-1:0] entry_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else if (load) begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB boundary: selects the write-back value at capture and holds results in a
// 2-entry skid buffer feeding the register-file write port, with a forwarding lookup.
//
// state    | meaning
// ST_EMPTY | no entries buffered, outputs idle
// ST_HALF  | main holds the head entry, skid empty
// ST_FULL  | main holds head, skid holds the younger entry; in_ready low
module mem_wb_skid_stage
    import mem_wb_skid_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int REG_AW = WB_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] data_memory_in,
    input  logic [REG_AW-1:0] dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en_out,
    output logic [DATA_W-1:0] wb_value_out,
    output logic [REG_AW-1:0] wb_dest_out,
    input  logic [REG_AW-1:0] fwd_src,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_value,
    output logic [1:0]        occupancy
);

    localparam int ENTRY_W = 1 + REG_AW + DATA_W;

    logic [1:0]         state_q, state_d;
    logic               in_ready_q;
    logic               in_fire, out_fire;
    logic [ENTRY_W-1:0] in_entry, main_d;
    logic               main_valid, skid_valid;
    logic [ENTRY_W-1:0] main_entry, skid_entry;
    logic               main_load, main_clr, main_from_skid;
    logic               skid_load, skid_clr;
    logic               main_hit, skid_hit;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = main_valid & out_ready;

    // The load/ALU choice is resolved here so mem_r_en never needs storing.
    assign in_entry = {wb_en_in, dest_in, (mem_r_en_in ? data_memory_in : alu_res_in)};

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = flush;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = flush;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_d   = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = ST_FULL;
                    end else if (out_fire) begin
                        main_clr = 1'b1;
                        state_d  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = ST_HALF;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_entry : in_entry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    wb_entry_reg #(.ENTRY_W(ENTRY_W)) u_main (
        .clk     (clk),
        .rst_n   (rst),
        .clear   (main_clr),
        .load    (main_load),
        .valid_d (1'b1),
        .entry_d (main_d),
        .valid_q (main_valid),
        .entry_q (main_entry)
    );

    wb_entry_reg #(.ENTRY_W(ENTRY_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst),
        .clear   (skid_clr),
        .load    (skid_load),
        .valid_d (1'b1),
        .entry_d (in_entry),
        .valid_q (skid_valid),
        .entry_q (skid_entry)
    );

    assign in_ready     = in_ready_q;
    assign out_valid    = main_valid;
    assign wb_en_out    = main_entry[ENTRY_W-1];
    assign wb_dest_out  = main_entry[DATA_W +: REG_AW];
    assign wb_value_out = main_entry[DATA_W-1:0];
    assign occupancy    = state_q;

    // Skid is the younger entry, so it wins when both match.
    assign skid_hit = skid_valid & skid_entry[ENTRY_W-1] & (skid_entry[DATA_W +: REG_AW] == fwd_src);
    assign main_hit = main_valid & main_entry[ENTRY_W-1] & (main_entry[DATA_W +: REG_AW] == fwd_src);
    assign fwd_hit  = skid_hit | main_hit;
    assign fwd_value = skid_hit ? skid_entry[DATA_W-1:0] :
                       main_hit ? main_entry[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Scoreboard bench for mem_wb_skid_stage: directed reset/pass-through/stall/forward/flush
// cases followed by a long random valid/ready run.
module tb_mem_wb_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic [31:0] alu_res_in;
    logic [31:0] data_memory_in;
    logic [3:0]  dest_in;
    logic        out_valid;
    logic        out_ready;
    logic        wb_en_out;
    logic [31:0] wb_value_out;
    logic [3:0]  wb_dest_out;
    logic [3:0]  fwd_src;
    logic        fwd_hit;
    logic [31:0] fwd_value;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    mem_wb_skid_stage dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .wb_en_in       (wb_en_in),
        .mem_r_en_in    (mem_r_en_in),
        .alu_res_in     (alu_res_in),
        .data_memory_in (data_memory_in),
        .dest_in        (dest_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .wb_en_out      (wb_en_out),
        .wb_value_out   (wb_value_out),
        .wb_dest_out    (wb_dest_out),
        .fwd_src        (fwd_src),
        .fwd_hit        (fwd_hit),
        .fwd_value      (fwd_value),
        .occupancy      (occupancy)
    );

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic we, input logic ld,
                          input logic [31:0] alu, input logic [31:0] dm, input logic [3:0] d);
        in_valid       = v;
        wb_en_in       = we;
        mem_r_en_in    = ld;
        alu_res_in     = alu;
        data_memory_in = dm;
        dest_in        = d;
    endtask

    // Called just after a falling edge with inputs settled: scores this cycle's
    // handshakes, advances one clock, then checks the buffer state against the model.
    task automatic tick();
        logic [36:0] e;
        #1;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk_val("spurious_wb", {27'd0, wb_en_out, wb_dest_out, wb_value_out}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk_val("wb_entry", {27'd0, wb_en_out, wb_dest_out, wb_value_out}, {27'd0, e});
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back({wb_en_in, dest_in, (mem_r_en_in ? data_memory_in : alu_res_in)});
        end
        @(posedge clk);
        @(negedge clk);
        chk_val("occupancy", {62'd0, occupancy}, 64'(exp_q.size()));
        chk_val("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
        chk_val("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        fwd_src = 4'd0;
        set_in(1'b1, 1'b1, 1'b0, 32'h5, 32'h6, 4'd1);

        // reset held with valid input
        repeat (3) @(negedge clk);
        chk_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk_val("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk_val("rst_occupancy", {62'd0, occupancy}, 64'd0);
        chk_val("rst_value", {32'd0, wb_value_out}, 64'd0);
        chk_val("rst_fwd_hit", {63'd0, fwd_hit}, 64'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_val("rel_in_ready_low", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        chk_val("rel_in_ready_high", {63'd0, in_ready}, 64'd1);

        // pass-through, load then non-load
        out_ready = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, 32'h10, 32'hAB, 4'd3);
        tick();
        chk_val("pt_dest", {60'd0, wb_dest_out}, 64'd3);
        chk_val("pt_load_value", {32'd0, wb_value_out}, 64'hAB);
        set_in(1'b1, 1'b1, 1'b0, 32'h10, 32'hAB, 4'd4);
        tick();
        chk_val("pt_alu_value", {32'd0, wb_value_out}, 64'h10);
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        tick();

        // stall and fill
        out_ready = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 32'hA1, 32'h0, 4'd7);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 32'hB2, 32'h0, 4'd8);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        chk_val("fill_head_a", {32'd0, wb_value_out}, 64'hA1);
        tick();
        chk_val("stall_head_stable", {27'd0, wb_en_out, wb_dest_out, wb_value_out}, {27'd0, 1'b1, 4'd7, 32'hA1});
        out_ready = 1'b1;
        tick();
        chk_val("drain_head_b", {32'd0, wb_value_out}, 64'hB2);
        chk_val("bubble_wb_en", {63'd0, wb_en_out}, 64'd0);
        tick();

        // forwarding: skid younger wins
        out_ready = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 4'd5);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 4'd5);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        fwd_src = 4'd5;
        #1;
        chk_val("fwd_hit_both", {63'd0, fwd_hit}, 64'd1);
        chk_val("fwd_youngest", {32'd0, fwd_value}, 64'h22);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 4'd5);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 32'h22, 32'h0, 4'd5);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        #1;
        chk_val("fwd_skip_no_wb", {32'd0, fwd_value}, 64'h11);
        fwd_src = 4'd6;
        #1;
        chk_val("fwd_miss_hit", {63'd0, fwd_hit}, 64'd0);
        chk_val("fwd_miss_value", {32'd0, fwd_value}, 64'd0);

        // flush while full with in/out attempts
        flush = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 32'h33, 32'h0, 4'd9);
        tick();
        flush = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        chk_val("flush_occupancy", {62'd0, occupancy}, 64'd0);
        chk_val("flush_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (3) tick();

        // reset mid-operation discards everything
        out_ready = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 4'd2);
        tick();
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        out_ready = 1'b1;
        rst = 1'b0;
        #1;
        chk_val("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk_val("midrst_occupancy", {62'd0, occupancy}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // random valid/ready/flush traffic
        for (int i = 0; i < 10000; i++) begin
            flush     = ($urandom_range(0, 199) == 0);
            out_ready = $urandom_range(0, 2) != 0;
            fwd_src   = 4'($urandom_range(0, 15));
            set_in($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   $urandom, $urandom, 4'($urandom_range(0, 15)));
            tick();
        end

        flush = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        repeat (3) tick();
        chk_val("final_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
